// File: rtl/generic_spi.sv
// CSR-launched SPI master: one 32-bit write picks device, mode, bit order and
// word length, then runs a single full-duplex transfer followed by a latch pulse.
module generic_spi #(
  parameter int CLK_RATE  = 100000000,
  parameter int BIT_RATE  = 12500000,
  parameter int CSB_WIDTH = 4,
  parameter int LE_WIDTH  = CSB_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 csrStrobe,
  input  logic [31:0]          gpioOut,
  output logic [31:0]          status,
  output logic                 SPI_CLK,
  output logic [CSB_WIDTH-1:0] SPI_CSB,
  output logic [LE_WIDTH-1:0]  SPI_LE,
  output logic                 SPI_SDI,
  input  logic                 SPI_SDO
);

  localparam int HDIV = CLK_RATE / (2 * BIT_RATE);
  localparam int H    = (HDIV < 1) ? 1 : HDIV;
  localparam int CW   = $clog2(H + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LATCH} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [5:0]             half_q, half_d;
  logic                   op24_q, op24_d;
  logic                   lsb_q, lsb_d;
  logic                   cpha_q, cpha_d;
  logic [3:0]             dev_q, dev_d;
  logic [23:0]            txr_q, txr_d;
  logic [23:0]            rx_q, rx_d;
  logic [23:0]            data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   sclk_q, sclk_d;
  logic                   sdi_q, sdi_d;
  logic [CSB_WIDTH-1:0]   csb_q, csb_d;
  logic [LE_WIDTH-1:0]    le_q, le_d;

  logic                   tick_end, last_half, leading;
  logic [23:0]            txr_init, rx_tmp;
  logic [CSB_WIDTH-1:0]   csb_sel;
  logic [LE_WIDTH-1:0]    le_sel;

  // The outgoing word is aligned so the next bit is always txr[0] (LSB first)
  // or txr[23] (MSB first), regardless of word length.
  function automatic logic head_bit(input logic [23:0] v, input logic lsb);
    return lsb ? v[0] : v[23];
  endfunction

  function automatic logic [23:0] shift_out(input logic [23:0] v, input logic lsb);
    return lsb ? {1'b0, v[23:1]} : {v[22:0], 1'b0};
  endfunction

  always_comb begin
    csb_sel = '0;
    for (int i = 0; i < CSB_WIDTH; i++) csb_sel[i] = (int'(gpioOut[27:24]) == i);
    le_sel = '0;
    for (int i = 0; i < LE_WIDTH; i++) le_sel[i] = (int'(dev_q) == i);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    op24_d   = op24_q;
    lsb_d    = lsb_q;
    cpha_d   = cpha_q;
    dev_d    = dev_q;
    txr_d    = txr_q;
    rx_d     = rx_q;
    data_d   = data_q;
    busy_d   = busy_q;
    sclk_d   = sclk_q;
    sdi_d    = sdi_q;
    csb_d    = csb_q;
    le_d     = le_q;

    tick_end  = (cnt_q == CW'(H - 1));
    last_half = (half_q == (op24_q ? 6'd47 : 6'd31));
    leading   = ~half_q[0];
    txr_init  = gpioOut[31] ? gpioOut[23:0]
              : (gpioOut[30] ? {8'h00, gpioOut[15:0]} : {gpioOut[15:0], 8'h00});

    rx_tmp = rx_q >> 1;
    if (op24_q) rx_tmp[23] = SPI_SDO;
    else        rx_tmp[15] = SPI_SDO;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (csrStrobe) begin
          op24_d  = gpioOut[31];
          lsb_d   = gpioOut[30];
          cpha_d  = gpioOut[28];
          dev_d   = gpioOut[27:24];
          sclk_d  = gpioOut[29];
          csb_d   = ~csb_sel;
          rx_d    = '0;
          half_d  = '0;
          busy_d  = 1'b1;
          state_d = SETUP;
          if (!gpioOut[28]) begin
            sdi_d = head_bit(txr_init, gpioOut[30]);
            txr_d = shift_out(txr_init, gpioOut[30]);
          end else begin
            txr_d = txr_init;
          end
        end
      end
      SETUP: begin
        cnt_d = tick_end ? '0 : cnt_q + CW'(1);
        if (tick_end) state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = tick_end ? '0 : cnt_q + CW'(1);
        if (tick_end) begin
          sclk_d = ~sclk_q;
          half_d = half_q + 6'd1;
          // Each clock edge either launches the next bit or captures SDO,
          // depending on CPHA; the final trailing edge launches nothing.
          if (leading == cpha_q) begin
            if (!last_half) begin
              sdi_d = head_bit(txr_q, lsb_q);
              txr_d = shift_out(txr_q, lsb_q);
            end
          end else begin
            rx_d = lsb_q ? rx_tmp : {rx_q[22:0], SPI_SDO};
          end
          if (last_half) state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = tick_end ? '0 : cnt_q + CW'(1);
        if (tick_end) begin
          csb_d   = '1;
          le_d    = le_sel;
          state_d = LATCH;
        end
      end
      LATCH: begin
        cnt_d = tick_end ? '0 : cnt_q + CW'(1);
        if (tick_end) begin
          le_d    = '0;
          busy_d  = 1'b0;
          data_d  = rx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      op24_q  <= 1'b0;
      lsb_q   <= 1'b0;
      cpha_q  <= 1'b0;
      dev_q   <= '0;
      txr_q   <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdi_q   <= 1'b0;
      csb_q   <= '1;
      le_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      op24_q  <= op24_d;
      lsb_q   <= lsb_d;
      cpha_q  <= cpha_d;
      dev_q   <= dev_d;
      txr_q   <= txr_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;
      csb_q   <= csb_d;
      le_q    <= le_d;
    end
  end

  assign status  = {busy_q, 7'b0, data_q};
  assign SPI_CLK = sclk_q;
  assign SPI_SDI = sdi_q;
  assign SPI_CSB = csb_q;
  assign SPI_LE  = le_q;

endmodule

// File: tb/tb_generic_spi.sv
// Bench for generic_spi: directed and random transfers against an SPI slave
// model that reconstructs the sent word and supplies a known reply.
module tb_generic_spi;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csrStrobe = 1'b0;
  logic [31:0] gpioOut = '0;
  logic [31:0] status;
  logic        SPI_CLK;
  logic [3:0]  SPI_CSB;
  logic [3:0]  SPI_LE;
  logic        SPI_SDI;
  logic        SPI_SDO = 1'b0;

  int errors = 0;
  int checks = 0;

  generic_spi dut (
    .clk(clk), .rst(rst), .csrStrobe(csrStrobe), .gpioOut(gpioOut),
    .status(status), .SPI_CLK(SPI_CLK), .SPI_CSB(SPI_CSB), .SPI_LE(SPI_LE),
    .SPI_SDI(SPI_SDI), .SPI_SDO(SPI_SDO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch word w, act as the slave returning pw, and check the whole transfer.
  // A second strobe with word iw is offered at cycle intrude_at (negative: never).
  task automatic xfer(input string tag, input logic [31:0] w, input logic [23:0] pw,
                      input int intrude_at, input logic [31:0] iw);
    int n, dev, busy_cnt, edges, last_edge, gap_bad, midx, sidx;
    int low_cnt, csb_bad, le_cnt, le_bad;
    logic lsb, cpol, cpha, prev, done;
    logic [23:0] tx, got, exp_rx;
    logic [3:0] exp_csb, exp_le;
    n    = w[31] ? 24 : 16;
    lsb  = w[30];
    cpol = w[29];
    cpha = w[28];
    dev  = int'(w[27:24]);
    tx   = (n == 24) ? w[23:0] : {8'h00, w[15:0]};
    exp_rx  = (n == 24) ? pw : {8'h00, pw[15:0]};
    exp_csb = (dev < 4) ? ~(4'b1 << dev) : 4'hF;
    exp_le  = (dev < 4) ? (4'b1 << dev) : 4'h0;
    busy_cnt = 0; edges = 0; last_edge = -1; gap_bad = 0; midx = 0; sidx = 0;
    low_cnt = 0; csb_bad = 0; le_cnt = 0; le_bad = 0; done = 1'b0;
    got = '0; prev = cpol;

    @(negedge clk);
    gpioOut = w; csrStrobe = 1'b1;
    @(negedge clk);
    csrStrobe = 1'b0;
    chk({tag, ".clk_idle_start"}, {31'b0, SPI_CLK}, {31'b0, cpol});
    chk({tag, ".csb_start"}, {28'b0, SPI_CSB}, {28'b0, exp_csb});
    if (!cpha) begin
      SPI_SDO = lsb ? pw[0] : pw[n-1];
      midx = 1;
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) begin
        csrStrobe = (cyc == intrude_at);
        if (cyc == intrude_at) gpioOut = iw;
        @(negedge clk);
      end
      if (!status[31]) begin
        done = 1'b1;
        break;
      end
      busy_cnt++;
      if (SPI_CSB != 4'hF) begin
        low_cnt++;
        if (SPI_CSB != exp_csb) csb_bad++;
      end
      if (SPI_LE != 4'h0) begin
        le_cnt++;
        if (SPI_LE != exp_le) le_bad++;
      end
      if (SPI_CLK != prev) begin
        edges++;
        if (last_edge >= 0 && cyc - last_edge != H) gap_bad++;
        last_edge = cyc;
        if ((SPI_CLK != cpol) == !cpha) begin
          // sampling edge for the slave: capture MOSI
          if (sidx < n) got[lsb ? sidx : n - 1 - sidx] = SPI_SDI;
          sidx++;
        end else if (midx < n) begin
          SPI_SDO = lsb ? pw[midx] : pw[n - 1 - midx];
          midx++;
        end
      end
      prev = SPI_CLK;
    end
    csrStrobe = 1'b0;

    chk({tag, ".done"}, {31'b0, done}, 32'd1);
    chk({tag, ".busy_cycles"}, busy_cnt, (2 * n + 3) * H);
    chk({tag, ".edges"}, edges, 2 * n);
    chk({tag, ".edge_gap_bad"}, gap_bad, 0);
    chk({tag, ".mosi_word"}, {8'h0, got}, {8'h0, tx});
    chk({tag, ".status"}, status, {8'h00, exp_rx});
    chk({tag, ".csb_low_cycles"}, low_cnt, (dev < 4) ? (2 * n + 2) * H : 0);
    chk({tag, ".csb_bad"}, csb_bad, 0);
    chk({tag, ".le_cycles"}, le_cnt, (dev < 4) ? H : 0);
    chk({tag, ".le_bad"}, le_bad, 0);
    chk({tag, ".clk_idle_end"}, {31'b0, SPI_CLK}, {31'b0, cpol});
  endtask

  initial begin
    logic [31:0] rw;
    logic [23:0] rp;

    // reset state, strobe while reset is held
    gpioOut = 32'h400007AA;
    csrStrobe = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.csb", {28'b0, SPI_CSB}, 32'hF);
    chk("rst.le", {28'b0, SPI_LE}, 32'h0);
    chk("rst.clk", {31'b0, SPI_CLK}, 32'h0);
    chk("rst.sdi", {31'b0, SPI_SDI}, 32'h0);
    chk("rst.status", status, 32'h0);
    csrStrobe = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst.status", status, 32'h0);
    chk("post_rst.csb", {28'b0, SPI_CSB}, 32'hF);

    xfer("t2_lsb_mode0", 32'h400007AA, 24'h00C3A5, -1, 32'h0);
    xfer("t3_mode1", 32'h500007AA, 24'h0055AA, -1, 32'h0);
    xfer("t4_24b_cpol", 32'hA2123456, 24'h9ABCDE, -1, 32'h0);
    xfer("t5_intrude", 32'h400007AA, 24'h001234, 40, 32'h400012FF);
    xfer("dev_oob", 32'hB9F0F00F, 24'h5A5A5A, -1, 32'h0);

    // reset during SHIFT aborts immediately
    @(negedge clk);
    gpioOut = 32'h800FEDCB; csrStrobe = 1'b1;
    @(negedge clk);
    csrStrobe = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort.pre_busy", {31'b0, status[31]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort.csb", {28'b0, SPI_CSB}, 32'hF);
    chk("abort.clk", {31'b0, SPI_CLK}, 32'h0);
    chk("abort.status", status, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    xfer("after_abort", 32'h30000ABC, 24'h00F00D, -1, 32'h0);

    for (int i = 0; i < 6; i++) begin
      rw = $urandom;
      rp = 24'($urandom);
      xfer($sformatf("rand%0d", i), rw, rp, -1, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
